// File: rtl/clkrst_pkg.sv
// clkrst_pkg: shared state encoding, widths and index-width helper for the reset/run sequencer
package clkrst_pkg;
  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    DONE    = 3'd2,
    ERROR   = 3'd3,
    TIMEOUT = 3'd4
  } state_t;
  localparam int ERRCNT_W = 16;
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clkrst_if.sv
// clkrst_if: error/halt inputs and status outputs of the reset/run sequencer
interface clkrst_if #(
  parameter int N_ERR = 1,
  parameter int CNT_W = 32
);
  localparam int IW = clkrst_pkg::idx_w(N_ERR);
  logic [N_ERR-1:0]                 err;
  logic                             halt;
  logic                             core_rst;
  logic [CNT_W-1:0]                 cycle_count;
  logic [2:0]                       state;
  logic                             done;
  logic                             error;
  logic                             timeout;
  logic [N_ERR-1:0]                 err_vec;
  logic [IW-1:0]                    err_first;
  logic [clkrst_pkg::ERRCNT_W-1:0]  err_cnt;
  modport master (
    output err, halt,
    input  core_rst, cycle_count, state, done, error, timeout, err_vec, err_first, err_cnt
  );
  modport slave (
    input  err, halt,
    output core_rst, cycle_count, state, done, error, timeout, err_vec, err_first, err_cnt
  );
endinterface

// File: rtl/clkrst_prio_enc.sv
// clkrst_prio_enc: index of the lowest set bit of i_vec (0 when none set)
module clkrst_prio_enc #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx
);
  // scan from the top so the lowest set bit wins
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_vec[i]) o_idx = W'(i);
  end
endmodule

// File: rtl/clkrst_seq.sv
// clkrst_seq: sequences core reset, counts run cycles and records DONE/ERROR/TIMEOUT status
module clkrst_seq
  import clkrst_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100004,
  parameter int N_ERR      = 1,
  parameter int CNT_W      = 32,
  parameter bit STICKY_ERR = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  clkrst_if.slave bus
);
  localparam int IW = idx_w(N_ERR);
  localparam int HW = idx_w(RST_CYCLES);
  state_t               r_state;
  state_t               w_next;
  logic [HW-1:0]        r_hold_cnt;
  logic                 r_core_rst;
  logic [CNT_W-1:0]     r_cnt;
  logic [N_ERR-1:0]     r_err_vec;
  logic [IW-1:0]        r_err_first;
  logic [ERRCNT_W-1:0]  r_err_cnt;
  logic                 w_any;
  logic [IW-1:0]        w_idx;
  logic [CNT_W-1:0]     w_cnt_inc;
  assign w_any     = |bus.err;
  assign w_cnt_inc = r_cnt + 1'b1;
  clkrst_prio_enc #(.N(N_ERR), .W(IW)) u_enc (.i_vec(bus.err), .o_idx(w_idx));
  // next state: hold countdown, then run exits by priority err > halt > limit
  always_comb begin
    w_next = r_state;
    if (r_state == HOLD)
      w_next = (r_hold_cnt == HW'(RST_CYCLES - 1)) ? RUN : HOLD;
    else if (r_state == RUN)
      w_next = (STICKY_ERR && w_any) ? ERROR :
               bus.halt ? DONE :
               (w_cnt_inc == CNT_W'(MAX_CYCLES)) ? TIMEOUT : RUN;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= HOLD;
    else r_state <= w_next;
  end
  // counters and error log advance only in HOLD/RUN; terminal states freeze them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt  <= '0;
      r_core_rst  <= 1'b1;
      r_cnt       <= '0;
      r_err_vec   <= '0;
      r_err_first <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_core_rst <= (w_next == HOLD);
      if (r_state == HOLD) r_hold_cnt <= r_hold_cnt + 1'b1;
      if (r_state == RUN) begin
        r_cnt     <= w_cnt_inc;
        r_err_vec <= r_err_vec | bus.err;
        if (w_any) r_err_cnt <= (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
        if (w_any && r_err_vec == '0) r_err_first <= w_idx;
      end
    end
  end
  assign bus.core_rst    = r_core_rst;
  assign bus.cycle_count = r_cnt;
  assign bus.state       = r_state;
  assign bus.done        = (r_state == DONE) || (r_state == ERROR) || (r_state == TIMEOUT);
  assign bus.error       = (r_state == ERROR) || ((r_state == DONE) && (r_err_vec != '0));
  assign bus.timeout     = (r_state == TIMEOUT);
  assign bus.err_vec     = r_err_vec;
  assign bus.err_first   = r_err_first;
  assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_clkrst_seq.sv
// tb_clkrst_seq: directed checks of reset release, halt, sticky/logging errors, timeout and resets
module tb_clkrst_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  clkrst_if #(.N_ERR(4), .CNT_W(32)) if_s ();
  clkrst_if #(.N_ERR(4), .CNT_W(32)) if_l ();
  clkrst_seq #(.RST_CYCLES(2), .MAX_CYCLES(20), .N_ERR(4), .CNT_W(32), .STICKY_ERR(1'b1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s.slave));
  clkrst_seq #(.RST_CYCLES(2), .MAX_CYCLES(20), .N_ERR(4), .CNT_W(32), .STICKY_ERR(1'b0))
    dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l.slave));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    if_s.err = '0; if_s.halt = 1'b0; if_l.err = '0; if_l.halt = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    if_s.err = '0; if_s.halt = 1'b0; if_l.err = '0; if_l.halt = 1'b0;
    rst_n = 1'b0;
    tick(3);
    checks++; if (if_s.state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", if_s.state); end
    checks++; if (if_s.core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b expected 1", if_s.core_rst); end
    checks++; if ({if_s.done, if_s.error, if_s.timeout} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {if_s.done, if_s.error, if_s.timeout}); end
    checks++; if (if_s.cycle_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", if_s.cycle_count); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (if_s.core_rst !== 1'b1 || if_s.state !== 3'd0) begin errors++; $display("FAIL rel_first_edge: core_rst %b state %0d expected 1/0", if_s.core_rst, if_s.state); end
    tick(1);
    checks++; if (if_s.core_rst !== 1'b0 || if_s.state !== 3'd1) begin errors++; $display("FAIL rel_second_edge: core_rst %b state %0d expected 0/1", if_s.core_rst, if_s.state); end
    checks++; if (if_s.cycle_count !== 32'd0) begin errors++; $display("FAIL rel_count: got %0d expected 0", if_s.cycle_count); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    checks++; if (if_s.state !== 3'd0 || if_s.core_rst !== 1'b1) begin errors++; $display("FAIL hold_restart: state %0d core_rst %b expected 0/1", if_s.state, if_s.core_rst); end
    tick(1);
    checks++; if (if_s.state !== 3'd1 || if_s.core_rst !== 1'b0) begin errors++; $display("FAIL hold_restart_run: state %0d core_rst %b expected 1/0", if_s.state, if_s.core_rst); end
  endtask

  task automatic test_halt();
    restart();
    tick(9);
    checks++; if (if_s.cycle_count !== 32'd9) begin errors++; $display("FAIL halt_pre_count: got %0d expected 9", if_s.cycle_count); end
    if_s.halt = 1'b1;
    tick(1);
    if_s.halt = 1'b0;
    checks++; if (if_s.state !== 3'd2) begin errors++; $display("FAIL halt_state: got %0d expected 2", if_s.state); end
    checks++; if ({if_s.done, if_s.error, if_s.timeout} !== 3'b100) begin errors++; $display("FAIL halt_flags: got %b expected 100", {if_s.done, if_s.error, if_s.timeout}); end
    checks++; if (if_s.cycle_count !== 32'd10) begin errors++; $display("FAIL halt_count: got %0d expected 10", if_s.cycle_count); end
    if_s.err = 4'hF;
    tick(20);
    if_s.err = '0;
    checks++; if (if_s.cycle_count !== 32'd10 || if_s.state !== 3'd2) begin errors++; $display("FAIL halt_frozen: count %0d state %0d expected 10/2", if_s.cycle_count, if_s.state); end
    checks++; if (if_s.err_vec !== 4'b0000 || if_s.err_cnt !== 16'd0) begin errors++; $display("FAIL halt_err_ignored: vec %b cnt %0d expected 0000/0", if_s.err_vec, if_s.err_cnt); end
  endtask

  task automatic test_sticky();
    restart();
    tick(4);
    if_s.err = 4'b1100;
    tick(1);
    if_s.err = '0;
    checks++; if (if_s.state !== 3'd3) begin errors++; $display("FAIL sticky_state: got %0d expected 3", if_s.state); end
    checks++; if ({if_s.done, if_s.error, if_s.timeout} !== 3'b110) begin errors++; $display("FAIL sticky_flags: got %b expected 110", {if_s.done, if_s.error, if_s.timeout}); end
    checks++; if (if_s.err_vec !== 4'b1100) begin errors++; $display("FAIL sticky_vec: got %b expected 1100", if_s.err_vec); end
    checks++; if (if_s.err_first !== 2'd2) begin errors++; $display("FAIL sticky_first: got %0d expected 2", if_s.err_first); end
    checks++; if (if_s.err_cnt !== 16'd1) begin errors++; $display("FAIL sticky_cnt: got %0d expected 1", if_s.err_cnt); end
    checks++; if (if_s.cycle_count !== 32'd5) begin errors++; $display("FAIL sticky_count: got %0d expected 5", if_s.cycle_count); end
  endtask

  task automatic test_timeout();
    restart();
    tick(19);
    checks++; if (if_s.cycle_count !== 32'd19 || if_s.state !== 3'd1) begin errors++; $display("FAIL to_pre: count %0d state %0d expected 19/1", if_s.cycle_count, if_s.state); end
    tick(1);
    checks++; if (if_s.state !== 3'd4) begin errors++; $display("FAIL to_state: got %0d expected 4", if_s.state); end
    checks++; if ({if_s.done, if_s.error, if_s.timeout} !== 3'b101) begin errors++; $display("FAIL to_flags: got %b expected 101", {if_s.done, if_s.error, if_s.timeout}); end
    checks++; if (if_s.cycle_count !== 32'd20) begin errors++; $display("FAIL to_count: got %0d expected 20", if_s.cycle_count); end
    if_s.err = 4'b0011;
    tick(3);
    if_s.err = '0;
    tick(2);
    checks++; if (if_s.err_vec !== 4'b0000 || if_s.err_cnt !== 16'd0 || if_s.state !== 3'd4) begin errors++; $display("FAIL to_err_ignored: vec %b cnt %0d state %0d expected 0000/0/4", if_s.err_vec, if_s.err_cnt, if_s.state); end
    checks++; if (if_s.cycle_count !== 32'd20) begin errors++; $display("FAIL to_frozen: got %0d expected 20", if_s.cycle_count); end
  endtask

  task automatic test_logging();
    restart();
    for (int c = 0; c < 13; c++) begin
      if_l.err  = (c == 3 || c == 7) ? 4'b0001 : (c == 9) ? 4'b1000 : 4'b0000;
      if_l.halt = (c == 12);
      tick(1);
    end
    if_l.err = '0;
    if_l.halt = 1'b0;
    checks++; if (if_l.state !== 3'd2) begin errors++; $display("FAIL log_state: got %0d expected 2", if_l.state); end
    checks++; if ({if_l.done, if_l.error, if_l.timeout} !== 3'b110) begin errors++; $display("FAIL log_flags: got %b expected 110", {if_l.done, if_l.error, if_l.timeout}); end
    checks++; if (if_l.err_cnt !== 16'd3) begin errors++; $display("FAIL log_cnt: got %0d expected 3", if_l.err_cnt); end
    checks++; if (if_l.err_vec !== 4'b1001) begin errors++; $display("FAIL log_vec: got %b expected 1001", if_l.err_vec); end
    checks++; if (if_l.err_first !== 2'd0) begin errors++; $display("FAIL log_first: got %0d expected 0", if_l.err_first); end
    checks++; if (if_l.cycle_count !== 32'd13) begin errors++; $display("FAIL log_count: got %0d expected 13", if_l.cycle_count); end
  endtask

  task automatic test_simultaneous();
    restart();
    tick(2);
    if_s.err = 4'b0001; if_s.halt = 1'b1;
    if_l.err = 4'b0010; if_l.halt = 1'b1;
    tick(1);
    if_s.err = '0; if_s.halt = 1'b0; if_l.err = '0; if_l.halt = 1'b0;
    checks++; if (if_s.state !== 3'd3 || if_s.cycle_count !== 32'd3) begin errors++; $display("FAIL simul_sticky: state %0d count %0d expected 3/3", if_s.state, if_s.cycle_count); end
    checks++; if (if_l.state !== 3'd2 || if_l.error !== 1'b1) begin errors++; $display("FAIL simul_log: state %0d error %b expected 2/1", if_l.state, if_l.error); end
    checks++; if (if_l.err_first !== 2'd1 || if_l.err_cnt !== 16'd1) begin errors++; $display("FAIL simul_log_first: first %0d cnt %0d expected 1/1", if_l.err_first, if_l.err_cnt); end
  endtask

  task automatic test_mid_reset();
    restart();
    if_l.err = 4'b0100;
    tick(1);
    if_l.err = '0;
    tick(3);
    checks++; if (if_l.err_cnt !== 16'd1 || if_l.cycle_count !== 32'd4) begin errors++; $display("FAIL mid_pre: cnt %0d count %0d expected 1/4", if_l.err_cnt, if_l.cycle_count); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checks++; if (if_l.state !== 3'd0 || if_l.core_rst !== 1'b1) begin errors++; $display("FAIL mid_state: state %0d core_rst %b expected 0/1", if_l.state, if_l.core_rst); end
    checks++; if (if_l.cycle_count !== 32'd0 || if_l.err_cnt !== 16'd0 || if_l.err_vec !== 4'b0000 || if_l.err_first !== 2'd0) begin errors++; $display("FAIL mid_cleared: count %0d cnt %0d vec %b first %0d expected all 0", if_l.cycle_count, if_l.err_cnt, if_l.err_vec, if_l.err_first); end
    if_l.err = 4'hF;
    tick(2);
    if_l.err = '0;
    checks++; if (if_l.state !== 3'd1 || if_l.core_rst !== 1'b0) begin errors++; $display("FAIL hold_err_run: state %0d core_rst %b expected 1/0", if_l.state, if_l.core_rst); end
    checks++; if (if_l.err_vec !== 4'b0000 || if_l.err_cnt !== 16'd0) begin errors++; $display("FAIL hold_err_ignored: vec %b cnt %0d expected 0000/0", if_l.err_vec, if_l.err_cnt); end
  endtask

  initial begin
    if_s.err = '0; if_s.halt = 1'b0; if_l.err = '0; if_l.halt = 1'b0;
    test_reset();
    test_halt();
    test_sticky();
    test_timeout();
    test_logging();
    test_simultaneous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clkrst_seq.md
Name: clkrst_seq

Overview:
- Synthesizable, parametrised successor to the fixed-period clock/reset generator.
- Sequences the DUT reset for a configurable number of cycles and counts run cycles up to a configurable limit.
- Monitors N error channels and records a terminal status: DONE, ERROR or TIMEOUT.
- Sits between the bench/board clock source and the processor top; the status outputs are read by the bench or exposed on debug pins.

Parameters:
- RST_CYCLES, 2: consecutive rising edges with rst_n high needed before the DUT leaves reset (≥1).
- MAX_CYCLES, 100004: run-cycle limit; reaching it causes TIMEOUT.
- N_ERR, 1: number of error input channels (≥1).
- CNT_W, 32: width of cycle_count; must hold MAX_CYCLES.
- STICKY_ERR, 1: 1 = the first error stops the run (ERROR state); 0 = log errors and keep running.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset for this block.
- err  in  N_ERR  per-channel error flags, sampled on posedge clk.
- halt  in  1  normal program completion, sampled on posedge clk.
- core_rst  out  1  active-high registered reset to the DUT.
- cycle_count  out  CNT_W  number of RUN edges.
- state  out  3  current state encoding.
- done  out  1  high in any terminal state.
- error  out  1  ERROR state, or DONE with err_vec≠0.
- timeout  out  1  TIMEOUT state.
- err_vec  out  N_ERR  sticky OR of err seen during RUN.
- err_first  out  max(1,$clog2(N_ERR))  lowest set err index at the first error edge.
- err_cnt  out  16  RUN edges with any err bit set; saturates at 16'hFFFF.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- rst_n sampled low on posedge clk:
  - state=HOLD, core_rst=1, hold_cnt=0.
  - cycle_count=0, err_vec=0, err_first=0, err_cnt=0.
  - done=error=timeout=0.
- All outputs are registered or decoded from registered state only.
- HOLD:
  - Each edge with rst_n=1 increments hold_cnt.
  - The edge on which hold_cnt==RST_CYCLES-1 moves to RUN; core_rst=0 from that edge.
  - err and halt are ignored in HOLD.
- RUN:
  - Every edge increments cycle_count, including the exit edge.
  - Exit priority on the same edge: err (when STICKY_ERR=1) > halt > limit.
  - Any err bit set:
    - err_vec |= err.
    - err_cnt+1 (saturating).
    - err_first captured only if err_vec was 0 before this edge.
    - If STICKY_ERR=1, go to ERROR.
  - halt=1 → DONE.
  - cycle_count+1==MAX_CYCLES with no exit above → TIMEOUT; cycle_count then reads MAX_CYCLES.
- DONE/ERROR/TIMEOUT:
  - Terminal; all counters and flags frozen.
  - err and halt ignored.
  - Left only by rst_n low.
  - core_rst stays 0.
- Flag rules:
  - done=1 in all three terminal states.
  - timeout=1 only in TIMEOUT.
  - error=1 in ERROR, or in DONE when err_vec≠0 (STICKY_ERR=0 mode).
- rst_n low mid-RUN: next edge returns to HOLD with all state cleared. A rst_n pulse during HOLD restarts hold_cnt.
- cycle_count never wraps: it is bounded by MAX_CYCLES.

Decomposition:
- Shared package clkrst_pkg holds:
  - state encoding: HOLD=3'd0, RUN=3'd1, DONE=3'd2, ERROR=3'd3, TIMEOUT=3'd4;
  - err_cnt width constant ERRCNT_W=16;
  - a function computing index width max(1,$clog2(N)).
- One sub-module: clkrst_prio_enc, a parametrised lowest-set-bit index encoder of width N_ERR used for err_first. Purely combinational.

Test Plan:
- Reset release (RST_CYCLES=2): rst_n low 3 edges, then high → core_rst=1 through the first rising edge with rst_n high, 0 after the second; state=RUN, cycle_count=0.
- Normal halt: halt asserted while cycle_count==9 → after that edge state=DONE, done=1, error=0, cycle_count=10; count stays 10 for 20 more edges.
- Sticky error (N_ERR=4): err=4'b1100 while cycle_count==4 → state=ERROR, error=1, err_vec=4'b1100, err_first=2, err_cnt=1, cycle_count=5.
- Timeout (MAX_CYCLES=20): no halt/err → timeout=1, done=1, cycle_count=20 exactly; err asserted afterwards has no effect.
- Logging mode (STICKY_ERR=0, N_ERR=4): bit0 pulses at counts 3 and 7, bit3 at 9, halt at 12 → DONE, error=1, err_cnt=3, err_vec=4'b1001, err_first=0, cycle_count=13.
- Simultaneous and reset cases:
  - err=1 and halt=1 on the same edge (STICKY_ERR=1) → ERROR.
  - rst_n low for one edge mid-RUN → state=HOLD, core_rst=1, all counters 0.
  - err asserted during HOLD → err_vec stays 0.
